// File: rtl/led_select_ctrl_pkg.sv
// Shared constants and the select-step helper for the LED select controller.
// Hardware and simulation debounce limits live here so the top level and benches agree.
package led_select_ctrl_pkg;

    localparam int DEBOUNCE_LIMIT_HW  = 250000;
    localparam int DEBOUNCE_LIMIT_SIM = 4;

    typedef logic [1:0] sel_t;

    // Up steps +1 and down steps -1, both modulo 4. Coincident events cancel.
    function automatic sel_t sel_next(input sel_t sel, input logic up, input logic down);
        sel_t result;
        result = sel;
        if (up && !down) begin
            result = sel + 2'd1;
        end else if (down && !up) begin
            result = sel - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/led_select_ctrl_debounce_filter.sv
// Two-flop synchronizer followed by a counting debounce filter for one raw switch.
// The debounced level flips only after DEBOUNCE_LIMIT consecutive clocks of disagreement.
module debounce_filter
    import led_select_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_HW
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int              CW   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] count;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            count    <= '0;
            o_Switch <= 1'b0;
        end else begin
            sync_1 <= i_Switch;
            sync_2 <= sync_1;
            // Any return to the current level discards the partial count.
            if (sync_2 == o_Switch) begin
                count <= '0;
            end else if (count == LAST) begin
                o_Switch <= sync_2;
                count    <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_select_ctrl.sv
// Turns debounced switch releases into a wrapping 2-bit LED select code.
// Switch 1 release steps up, switch 2 release steps down; a changed pulse marks each new code.
module led_select_ctrl
    import led_select_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_HW
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_Select_0,
    output logic o_Select_1,
    output logic o_Select_Changed
);

    logic sw1_deb;
    logic sw2_deb;
    logic sw1_prev;
    logic sw2_prev;
    logic up_evt;
    logic down_evt;
    sel_t sel;
    logic changed;

    debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_filter_1 (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch_1),
        .o_Switch (sw1_deb)
    );

    debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_filter_2 (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch_2),
        .o_Switch (sw2_deb)
    );

    // Release (falling debounced level) is the action, so a held switch never repeats.
    assign up_evt   = sw1_prev & ~sw1_deb;
    assign down_evt = sw2_prev & ~sw2_deb;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sw1_prev <= 1'b0;
            sw2_prev <= 1'b0;
            sel      <= 2'b00;
            changed  <= 1'b0;
        end else begin
            sw1_prev <= sw1_deb;
            sw2_prev <= sw2_deb;
            sel      <= sel_next(sel, up_evt, down_evt);
            changed  <= up_evt ^ down_evt;
        end
    end

    assign o_Select_0       = sel[0];
    assign o_Select_1       = sel[1];
    assign o_Select_Changed = changed;

endmodule

// File: tb/tb_led_select_ctrl.sv
// Directed bench for led_select_ctrl with a history-window reference model checked every cycle.
module tb_led_select_ctrl;
    import led_select_ctrl_pkg::*;

    localparam int DL = DEBOUNCE_LIMIT_SIM;

    logic clk;
    logic rst;
    logic sw1;
    logic sw2;
    logic sel0;
    logic sel1;
    logic chg;

    int n_assert;
    int n_fail;

    led_select_ctrl #(.DEBOUNCE_LIMIT(DL)) dut (
        .i_Clk            (clk),
        .i_Rst            (rst),
        .i_Switch_1       (sw1),
        .i_Switch_2       (sw2),
        .o_Select_0       (sel0),
        .o_Select_1       (sel1),
        .o_Select_Changed (chg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: raw samples per edge; a debounced level flips when the synced
    // input (raw delayed two edges) disagreed with it on each of the last DL edges.
    int h1 [0:DL+1];
    int h2 [0:DL+1];
    int d1, d2;
    int pend_up, pend_dn;
    int msel, mchg;

    task automatic model_clear();
        for (int i = 0; i <= DL + 1; i++) begin
            h1[i] = 0;
            h2[i] = 0;
        end
        d1 = 0; d2 = 0; pend_up = 0; pend_dn = 0; msel = 0; mchg = 0;
    endtask

    task automatic model_edge();
        int f1, f2;
        mchg = (pend_up != pend_dn) ? 1 : 0;
        if (pend_up == 1 && pend_dn == 0) msel = (msel + 1) % 4;
        else if (pend_dn == 1 && pend_up == 0) msel = (msel + 3) % 4;
        for (int i = DL + 1; i >= 1; i--) begin
            h1[i] = h1[i-1];
            h2[i] = h2[i-1];
        end
        h1[0] = int'(sw1);
        h2[0] = int'(sw2);
        f1 = 1; f2 = 1;
        for (int i = 2; i <= DL + 1; i++) begin
            if (h1[i] == d1) f1 = 0;
            if (h2[i] == d2) f2 = 0;
        end
        pend_up = (f1 == 1 && d1 == 1) ? 1 : 0;
        pend_dn = (f2 == 1 && d2 == 1) ? 1 : 0;
        if (f1 == 1) d1 = 1 - d1;
        if (f2 == 1) d2 = 1 - d2;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else model_edge();
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_sel();
        return int'({sel1, sel0});
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            chk("model_sel", cur_sel(), msel);
            chk("model_chg", int'(chg), mchg);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap1(input int hold_n, input int after_n);
        sw1 = 1'b1; tick(hold_n);
        sw1 = 1'b0; tick(after_n);
    endtask

    task automatic tap2(input int hold_n, input int after_n);
        sw2 = 1'b1; tick(hold_n);
        sw2 = 1'b0; tick(after_n);
    endtask

    task automatic count_pulses(input int n, output int pulses, output int saw2);
        pulses = 0;
        saw2   = 0;
        repeat (n) begin
            @(negedge clk);
            if (chg) pulses++;
            if (cur_sel() == 2) saw2 = 1;
        end
    endtask

    int pulses;
    int saw2;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        sw1 = 1'b0;
        sw2 = 1'b0;
        tick(3);
        #2 rst = 1'b0;
        tick(2);
        chk("reset_sel", cur_sel(), 0);
        chk("reset_chg", int'(chg), 0);

        // Clean step up: release lands DL+2 edges after the capturing edge.
        sw1 = 1'b1; tick(20);
        chk("press_no_change", cur_sel(), 0);
        sw1 = 1'b0;
        tick(6);
        chk("step_before_sel", cur_sel(), 0);
        chk("step_before_chg", int'(chg), 0);
        tick(1);
        chk("step_sel", cur_sel(), 1);
        chk("step_chg", int'(chg), 1);
        tick(1);
        chk("step_chg_drop", int'(chg), 0);
        tick(10);

        // Bounce rejection: 3-clock pulses never survive the filter.
        for (int i = 0; i < 5; i++) begin
            sw1 = 1'b1; tick(3);
            sw1 = 1'b0; tick(3);
        end
        tick(12);
        chk("bounce_sel", cur_sel(), 1);

        // Glitch low while held high produces no release.
        sw1 = 1'b1; tick(20);
        sw1 = 1'b0; tick(3);
        sw1 = 1'b1; tick(20);
        chk("glitch_sel", cur_sel(), 1);
        sw1 = 1'b0; tick(12);
        chk("glitch_release_sel", cur_sel(), 2);

        // Asynchronous reset with sel=2, no clock edge needed.
        tick(1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sel0", int'(sel0), 0);
        chk("async_rst_sel1", int'(sel1), 0);
        chk("async_rst_chg", int'(chg), 0);
        tick(2);
        #2 rst = 1'b0;
        tick(10);
        chk("post_rst_idle_sel", cur_sel(), 0);

        // Wrap in both directions.
        tap1(8, 12); chk("wrap_1", cur_sel(), 1);
        tap1(8, 12); chk("wrap_2", cur_sel(), 2);
        tap1(8, 12); chk("wrap_3", cur_sel(), 3);
        tap1(8, 12); chk("wrap_0", cur_sel(), 0);
        tap2(8, 12); chk("wrap_down_3", cur_sel(), 3);

        tap1(8, 12);
        tap1(8, 12);
        chk("simul_setup", cur_sel(), 1);

        // Simultaneous releases cancel.
        sw1 = 1'b1; sw2 = 1'b1; tick(10);
        sw1 = 1'b0; sw2 = 1'b0;
        count_pulses(12, pulses, saw2);
        chk("simul_pulses", pulses, 0);
        chk("simul_sel", cur_sel(), 1);

        // Releases one clock apart: +1 then -1.
        sw1 = 1'b1; sw2 = 1'b1; tick(10);
        sw1 = 1'b0; tick(1);
        sw2 = 1'b0;
        count_pulses(12, pulses, saw2);
        chk("offset_pulses", pulses, 2);
        chk("offset_saw_2", saw2, 1);
        chk("offset_sel", cur_sel(), 1);

        // Reset during a release's debounce discards it.
        sw2 = 1'b1; tick(10);
        sw2 = 1'b0; tick(2);
        #2 rst = 1'b1;
        tick(1);
        #2 rst = 1'b0;
        count_pulses(12, pulses, saw2);
        chk("mid_deb_pulses", pulses, 0);
        chk("mid_deb_sel", cur_sel(), 0);
        tap2(8, 12);
        chk("mid_deb_next_sel", cur_sel(), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
